// File: rtl/sigma_irq_ctrl_if.sv
// rtl/sigma_irq_ctrl_if.sv - core-side request/acknowledge handshake of the interrupt controller
interface sigma_irq_ctrl_if #(
   parameter int IRQ_NUM_POW = 4
);
   logic                   irq_req_o;
   logic [IRQ_NUM_POW-1:0] irq_code_bo;
   logic                   irq_ack_i;

   modport master (
      output irq_req_o,
      output irq_code_bo,
      input  irq_ack_i
   );

   modport slave (
      input  irq_req_o,
      input  irq_code_bo,
      output irq_ack_i
   );
endinterface

// File: rtl/sigma_irq_ctrl.sv
// rtl/sigma_irq_ctrl.sv - per-tile interrupt controller: pending register, fixed-priority arbiter, req/ack FSM
module sigma_irq_ctrl #(
   parameter int IRQ_NUM_POW   = 4,
   parameter int TIMER_IRQ_NUM = 0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [(2**IRQ_NUM_POW)-1:0] irq_bi,
   input  logic [(2**IRQ_NUM_POW)-1:0] irq_en_bi,
   input  logic                        irq_timer_i,
   input  logic                        sgi_req_i,
   input  logic [IRQ_NUM_POW-1:0]      sgi_code_bi,
   sigma_irq_ctrl_if.master            core,
   output logic [(2**IRQ_NUM_POW)-1:0] irq_pending_bo
);
   localparam int N = 2**IRQ_NUM_POW;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_t;

   state_t                 state;
   logic [N-1:0]           pending;
   logic [N-1:0]           irq_prev;
   logic [N-1:0]           set_vec;
   logic [N-1:0]           clr_vec;
   logic [N-1:0]           eligible;
   logic [IRQ_NUM_POW-1:0] win_code;
   logic                   irq_req_q;
   logic [IRQ_NUM_POW-1:0] irq_code_q;

   always_comb begin
      set_vec = irq_bi & ~irq_prev;
      if (irq_timer_i)
         set_vec[TIMER_IRQ_NUM] = 1'b1;
      if (sgi_req_i)
         set_vec[sgi_code_bi] = 1'b1;
   end

   always_comb begin
      clr_vec = '0;
      if (state == REQ && core.irq_ack_i)
         clr_vec[irq_code_q] = 1'b1;
   end

   assign eligible = pending & irq_en_bi;

   // Scan from the top down so the lowest eligible index is the last to win.
   always_comb begin
      win_code = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (eligible[i])
            win_code = IRQ_NUM_POW'(i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending  <= '0;
         irq_prev <= '0;
      end else begin
         pending  <= (pending & ~clr_vec) | set_vec;
         irq_prev <= irq_bi;
      end
   end

   // The request is frozen in REQ; only an ack (or reset) releases it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         irq_req_q  <= 1'b0;
         irq_code_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (eligible != '0) begin
                  irq_code_q <= win_code;
                  irq_req_q  <= 1'b1;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (core.irq_ack_i) begin
                  irq_req_q <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               irq_req_q <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign core.irq_req_o   = irq_req_q;
   assign core.irq_code_bo = irq_code_q;
   assign irq_pending_bo   = pending;
endmodule

// File: doc/sigma_irq_ctrl.md
Name: sigma_irq_ctrl

Overview:
- Per-tile interrupt controller that sits directly downstream of the tile SFR block.
- Consumes the SFR's IRQ enable mask, timer interrupt pulse and software-generated-interrupt (SGI) request/code.
- Merges them with external interrupt lines into a pending register.
- Presents one prioritised interrupt request with a code to the core over a req/ack handshake.

Parameters:
- IRQ_NUM_POW, 4, log2 of the number of interrupt lines; N = 2**IRQ_NUM_POW.
- TIMER_IRQ_NUM, 0, pending bit set by the timer pulse; range 0..N-1.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- irq_bi  input  N  external interrupt lines, rising-edge sensitive.
- irq_en_bi  input  N  enable mask from SFR irq_en_bo.
- irq_timer_i  input  1  one-cycle timer pulse from SFR irq_timer.
- sgi_req_i  input  1  one-cycle SGI strobe from SFR sgi_req_o.
- sgi_code_bi  input  IRQ_NUM_POW  SGI line index from SFR sgi_code_bo.
- irq_req_o  output  1  interrupt request to core.
- irq_code_bo  output  IRQ_NUM_POW  index of the requested line; valid while irq_req_o=1.
- irq_ack_i  input  1  core acknowledge.
- irq_pending_bo  output  N  pending register, for debug/readback.

Behaviour:
- Reset (asynchronous, on rst_i high):
  - pending=0, irq_prev=0, state=IDLE.
  - irq_req_o=0, irq_code_bo=0.
- Edge detect:
  - irq_prev is a registered copy of irq_bi.
  - edge[i] = irq_bi[i] & ~irq_prev[i].
  - A line already high at reset release registers as an edge on the first clock after reset.
- Set sources, OR-combined per clock into set_vec:
  - edge vector.
  - irq_timer_i sets bit TIMER_IRQ_NUM.
  - sgi_req_i sets bit sgi_code_bi.
- Pending update per clock: pending <= (pending & ~clr_vec) | set_vec.
  - clr_vec is one-hot of irq_code_bo when in REQ and irq_ack_i=1; otherwise 0.
  - If set and clear hit the same bit in the same cycle, set wins; the new event is not lost.
- Masking:
  - Only eligible = pending & irq_en_bi take part in arbitration.
  - Masked pending bits are retained and delivered once enabled.
- Priority: fixed, lowest index highest. Arbitration is combinational over eligible.
- FSM with 2 states:
  - IDLE: if eligible != 0 at a clock edge, latch irq_code_bo = winning index, irq_req_o <= 1, go to REQ.
  - REQ:
    - irq_req_o and irq_code_bo are held stable until ack.
    - Clearing the enable bit or arrival of a higher-priority request does not retract or change the request.
    - On irq_ack_i=1 at a clock edge: clear the pending bit, irq_req_o <= 0, go to IDLE.
  - irq_ack_i in IDLE is ignored.
- Latency:
  - irq_bi rising, sampled at edge k: pending bit set after edge k; irq_req_o high after edge k+1.
  - The same latency applies to irq_timer_i and sgi_req_i.
- Back-to-back requests: irq_req_o is low for at least one cycle between consecutive requests, because IDLE re-arbitrates at the next edge.
- Re-trigger: a line's re-trigger while it is already pending is absorbed; one pending bit counts as one delivery.
- Mid-operation reset: rst_i asserted at any time, including in REQ, immediately drops irq_req_o and clears all pending state. No ack is required afterwards.
- irq_pending_bo is a direct copy of the pending register.

Test Plan:
1. Reset, irq_en_bi=16'h0008, pulse irq_bi[3] for 1 cycle -> irq_pending_bo=16'h0008 after 1 clock; irq_req_o=1 with irq_code_bo=3 after 2 clocks; ack -> irq_req_o=0, pending=0 next cycle.
2. irq_en_bi=16'hFFFF, irq_timer_i pulse and sgi_req_i with sgi_code_bi=5 in the same cycle -> pending=16'h0021; codes 0 then 5 delivered in order; irq_req_o low for at least 1 cycle between them.
3. irq_en_bi=0, rising edge on irq_bi[7] -> pending bit 7 set, irq_req_o stays 0 for 20 cycles; then set irq_en_bi=16'h0080 -> irq_req_o=1, code 7 two cycles later.
4. In REQ with code 2, raise irq_bi[0] and clear irq_en_bi[2] -> irq_req_o and code stay at 2 until ack; then code 0 is requested.
5. In REQ with code 4, ack together with a new sgi_req_i for code 4 -> pending bit 4 remains set; a second request with code 4 follows.
6. Assert rst_i asynchronously mid-clock during REQ -> irq_req_o=0 and irq_pending_bo=0 immediately, before the next clock edge; a held-high irq_bi[1] after reset release produces code 1.
